hpdcache_bank_rsp_collector: RTL and testbench
==============================================

// Module: hpdcache_bank_rsp_collector
// PURPOSE
//  Response-side return path from the nBanks cache banks back to the nReqs core requesters.
//  Each bank response is steered by its sid field into a per-(requester,bank) FIFO.
//  Each requester drains one response per cycle, round-robin across banks.
//  Responses from several banks to the same requester in one cycle are buffered, never lost.
//  Banks get backpressure through bank_rsp_ready_o. Requesters are always ready.
// PARAMETERS
//  HPDcacheCfg     '0     config struct; nReqs = .u.nRequesters, nBanks = .u.nBanks
//  hpdcache_rsp_t  logic  response type; must contain field sid (requester index)
//  FifoDepth       2      entries per (requester,bank) FIFO; >=1
// PORTS
//  clk_i             in   1                        clock, rising edge
//  rst_ni            in   1                        asynchronous reset, active-low
//  bank_rsp_valid_i  in   1 [nBanks]               bank b presents a response
//  bank_rsp_ready_o  out  1 [nBanks]               collector accepts bank b response
//  bank_rsp_i        in   hpdcache_rsp_t [nBanks]  response payload incl. sid
//  core_rsp_valid_o  out  1 [nReqs]                response valid for requester r (no ready)
//  core_rsp_o        out  hpdcache_rsp_t [nReqs]   response payload for requester r
// BEHAVIOUR
//  - Reset (async, rst_ni=0):
//    - all FIFOs empty; all RR pointers = bank 0
//    - core_rsp_valid_o = 0; bank_rsp_ready_o = 1; core_rsp_o = don't-care
//    - reset mid-traffic discards all buffered responses.
//  - Accept:
//    - transfer on bank_rsp_valid_i[b] & bank_rsp_ready_o[b]; pushed into FIFO[sid][b]
//    - a bank holds valid and payload stable until it sees ready.
//  - Ready: bank_rsp_ready_o[b] = no FIFO in column b is full.
//    - depends on registered state only; no combinational path from any input.
//    - a pop in the same cycle does NOT free a slot for that cycle's push; the slot is seen next cycle.
//  - Latency: push at cycle N -> earliest core_rsp_valid_o at cycle N+1 (no bypass).
//  - Drain, per requester r, each cycle:
//    - the RR arbiter (hpdcache_rrarb, N=nBanks) picks one non-empty FIFO[r][*]
//    - that FIFO head drives core_rsp_o[r] with core_rsp_valid_o[r]=1, then pops at clock edge
//    - RR priority moves to the bank after the granted one, wrapping nBanks-1 -> 0
//    - all FIFOs[r][*] empty -> core_rsp_valid_o[r]=0
//  - Throughput:
//    - one response per requester per cycle; all requesters drain in parallel
//    - one accepted response per bank per cycle.
//  - Ordering:
//    - per (requester,bank) pair: FIFO order is preserved
//    - across banks: no ordering guarantee.
//  - FIFO boundaries:
//    - full: ready drops the cycle after the FifoDepth-th push
//    - empty + push: valid out next cycle
//    - full + pop: ready reasserts next cycle
//    - occupancy counters are $clog2(FifoDepth+1) bits; pointers wrap at FifoDepth-1 -> 0.
//  - sid >= nReqs: the response is accepted and dropped. An assertion fires.
//  - nBanks==1: the arbiter degenerates to a pass-through of FIFO[r][0].
//  - Assertions:
//    - no push to a full FIFO
//    - bank payload stable while valid & !ready
//    - sid < nReqs.
// STRUCTURE
//  - hpdcache_pkg: hpdcache_cfg_t (existing).
//    - Add localparam HPDCACHE_RSP_FIFO_DEPTH_DEFAULT = 2.
//  - Sub-module hpdcache_rsp_fifo: parameterised 1W1R register FIFO.
//    - ports: push/pop, full/empty, head data; instantiated nReqs x nBanks.
//  - Per requester: one hpdcache_rrarb plus one-hot hpdcache_mux (NINPUT=nBanks) for the payload.
// TESTING (nReqs=2, nBanks=4, FifoDepth=2)
//  - Single: bank2 sends sid=1 at cycle 5.
//    -> core_rsp_valid_o[1]=1 at cycle 6 with that payload; requester 0 stays idle.
//  - Collision: banks 0..3 all send sid=0 in cycle 10.
//    -> requester 0 gets 4 responses, one per cycle 11..14, order 0,1,2,3; all readies stay 1.
//  - Backpressure: bank1 sends sid=0 for 3 consecutive cycles while banks 0,2,3 flood sid=0.
//    -> bank_rsp_ready_o[1]=0 once FIFO[0][1] holds 2 entries.
//    -> no loss; per-bank order preserved.
//  - Parallel: bank0 sends sid=0 and bank3 sends sid=1 in the same cycle.
//    -> both requesters valid next cycle, in parallel.
//  - Reset: rst_ni=0 with 5 buffered responses.
//    -> all core_rsp_valid_o=0 and all bank_rsp_ready_o=1 immediately; nothing is emitted after release.
//  - Bad sid: sid=3.
//    -> accepted, dropped, assertion reported, no core output.

Source files
------------

// File: rtl/hpdcache_bank_rsp_collector_pkg.sv
// Shared configuration types, default response format and small helpers
// for the bank-to-requester response collector.
package hpdcache_bank_rsp_collector_pkg;

  typedef struct packed {
    int unsigned nRequesters;
    int unsigned nBanks;
  } hpdcache_user_cfg_t;

  typedef struct packed {
    hpdcache_user_cfg_t u;
  } hpdcache_cfg_t;

  localparam int unsigned HPDCACHE_RSP_FIFO_DEPTH_DEFAULT = 2;

  localparam hpdcache_cfg_t HPDCACHE_CFG_DEFAULT = '{u: '{nRequesters: 2, nBanks: 4}};

  // Default response payload; any replacement type must carry a sid field.
  typedef struct packed {
    logic [1:0]  sid;
    logic [15:0] data;
  } hpdcache_rsp_default_t;

  // Increment an index modulo n (n >= 1).
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/hpdcache_bank_rsp_collector_fifo.sv
// Single-write single-read register FIFO holding responses for one
// (requester, bank) pair. Full/empty come from registered occupancy only.
module hpdcache_rsp_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter type         data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  data_t data_i,
  input  logic  pop_i,
  output logic  full_o,
  output logic  empty_o,
  output data_t data_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  data_t         mem_q [DEPTH];
  data_t         mem_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Next occupancy, pointer and storage state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by the counter.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // A push must never target a full FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(push_i && full_o))
        else $error("rsp_fifo: push while full");
    end
  end

endmodule

// File: rtl/hpdcache_bank_rsp_collector_rrarb.sv
// Round-robin arbiter and one-hot payload multiplexer used per requester.
module hpdcache_rrarb
  import hpdcache_bank_rsp_collector_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] prio_q, prio_d;

  // Grant the first requester at or after the priority index; priority then
  // moves to the slot after the winner. With N==1 this is a pass-through.
  always_comb begin
    int unsigned idx;
    int unsigned sel;
    logic        found;
    gnt_o = '0;
    found = 1'b0;
    sel   = 0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(prio_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[PW'(idx)]) begin
        gnt_o[PW'(idx)] = 1'b1;
        found           = 1'b1;
        sel             = idx;
      end
    end
    prio_d = prio_q;
    if (found) prio_d = PW'(rr_wrap_inc(sel, N));
  end

  // Priority pointer, starting at index 0 after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prio_q <= '0;
    else         prio_q <= prio_d;
  end

endmodule

module hpdcache_mux #(
  parameter int unsigned NINPUT = 4,
  parameter type         data_t = logic
) (
  input  data_t              data_i [NINPUT],
  input  logic [NINPUT-1:0]  sel_i,
  output data_t              data_o
);

  localparam int unsigned DW = $bits(data_t);

  // AND-OR selection; sel_i is one-hot or zero.
  always_comb begin
    logic [DW-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < NINPUT; i++) begin
      if (sel_i[i]) acc = acc | DW'(data_i[i]);
    end
    data_o = data_t'(acc);
  end

endmodule

// File: rtl/hpdcache_bank_rsp_collector.sv
// Steers bank responses by sid into per-(requester,bank) FIFOs and drains
// one response per requester per cycle with round-robin across banks.
module hpdcache_bank_rsp_collector
  import hpdcache_bank_rsp_collector_pkg::*;
#(
  parameter hpdcache_cfg_t HPDcacheCfg    = HPDCACHE_CFG_DEFAULT,
  parameter type           hpdcache_rsp_t = hpdcache_rsp_default_t,
  parameter int unsigned   FifoDepth      = HPDCACHE_RSP_FIFO_DEPTH_DEFAULT,
  localparam int unsigned  NREQS          = HPDcacheCfg.u.nRequesters,
  localparam int unsigned  NBANKS         = HPDcacheCfg.u.nBanks
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NBANKS-1:0]   bank_rsp_valid_i,
  output logic [NBANKS-1:0]   bank_rsp_ready_o,
  input  hpdcache_rsp_t       bank_rsp_i [NBANKS],
  output logic [NREQS-1:0]    core_rsp_valid_o,
  output hpdcache_rsp_t       core_rsp_o [NREQS]
);

  logic [NREQS-1:0][NBANKS-1:0] fifo_full;
  logic [NBANKS-1:0]            bank_acc;

  // A bank is ready when no FIFO in its column is full. Only registered
  // occupancy feeds this, so a same-cycle pop never frees a slot early.
  always_comb begin
    bank_rsp_ready_o = '1;
    for (int unsigned b = 0; b < NBANKS; b++) begin
      for (int unsigned r = 0; r < NREQS; r++) begin
        if (fifo_full[r][b]) bank_rsp_ready_o[b] = 1'b0;
      end
    end
  end

  assign bank_acc = bank_rsp_valid_i & bank_rsp_ready_o;

  for (genvar r = 0; r < NREQS; r++) begin : g_req
    logic [NBANKS-1:0] push_r;
    logic [NBANKS-1:0] empty_r;
    logic [NBANKS-1:0] gnt_r;
    hpdcache_rsp_t     head_r [NBANKS];

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      // Out-of-range sids match no requester, so they are accepted and dropped.
      assign push_r[b] = bank_acc[b] & (32'(bank_rsp_i[b].sid) == r);

      hpdcache_rsp_fifo #(
        .DEPTH  (FifoDepth),
        .data_t (hpdcache_rsp_t)
      ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_r[b]),
        .data_i  (bank_rsp_i[b]),
        .pop_i   (gnt_r[b]),
        .full_o  (fifo_full[r][b]),
        .empty_o (empty_r[b]),
        .data_o  (head_r[b])
      );
    end

    hpdcache_rrarb #(
      .N (NBANKS)
    ) i_rrarb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (~empty_r),
      .gnt_o  (gnt_r)
    );

    hpdcache_mux #(
      .NINPUT (NBANKS),
      .data_t (hpdcache_rsp_t)
    ) i_mux (
      .data_i (head_r),
      .sel_i  (gnt_r),
      .data_o (core_rsp_o[r])
    );

    // Requesters are always ready, so a grant is both the valid and the pop.
    assign core_rsp_valid_o[r] = |gnt_r;
  end

  logic [NBANKS-1:0] hold_vld_q, hold_vld_d;
  hpdcache_rsp_t     hold_rsp_q [NBANKS];
  hpdcache_rsp_t     hold_rsp_d [NBANKS];

  // Remember which banks were stalled and what they presented.
  always_comb begin
    hold_vld_d = bank_rsp_valid_i & ~bank_rsp_ready_o;
    hold_rsp_d = bank_rsp_i;
  end

  // Stall flags are control state and clear on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hold_vld_q <= '0;
    else         hold_vld_q <= hold_vld_d;
  end

  // Stalled payload snapshot, compared against the next cycle's payload.
  always_ff @(posedge clk_i) begin
    hold_rsp_q <= hold_rsp_d;
  end

  // Protocol checks: stalled banks keep payload stable, sids stay in range.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int unsigned b = 0; b < NBANKS; b++) begin
        if (hold_vld_q[b]) begin
          assert (bank_rsp_valid_i[b] && (bank_rsp_i[b] == hold_rsp_q[b]))
            else $error("rsp_collector: bank %0d changed while stalled", b);
        end
        if (bank_acc[b]) begin
          assert (32'(bank_rsp_i[b].sid) < NREQS)
            else $warning("rsp_collector: bank %0d sid %0d out of range, response dropped",
                          b, bank_rsp_i[b].sid);
        end
      end
    end
  end

endmodule

// File: tb/tb_hpdcache_bank_rsp_collector.sv
// Directed and random stimulus for the response collector, checked against
// a queue-based reference model (2 requesters, 4 banks, depth 2).
module tb_hpdcache_bank_rsp_collector;
  import hpdcache_bank_rsp_collector_pkg::*;

  localparam int NR    = 2;
  localparam int NB    = 4;
  localparam int DEPTH = 2;
  localparam hpdcache_cfg_t CFG = '{u: '{nRequesters: 2, nBanks: 4}};

  typedef hpdcache_rsp_default_t rsp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NB-1:0] bvld = '0;
  logic [NB-1:0] brdy;
  rsp_t          brsp [NB];
  logic [NR-1:0] cvld;
  rsp_t          crsp [NR];

  always #5 clk = ~clk;

  hpdcache_bank_rsp_collector #(
    .HPDcacheCfg    (CFG),
    .hpdcache_rsp_t (rsp_t),
    .FifoDepth      (DEPTH)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .bank_rsp_valid_i (bvld),
    .bank_rsp_ready_o (brdy),
    .bank_rsp_i       (brsp),
    .core_rsp_valid_o (cvld),
    .core_rsp_o       (crsp)
  );

  // Reference model: one queue per (requester, bank), a next-bank pointer per requester.
  rsp_t mq [NR][NB][$];
  int   ptr [NR];
  bit   exp_v [NR];
  int   exp_b [NR];
  rsp_t exp_d [NR];
  bit   exp_rdy [NB];

  int   vectors = 0;
  int   miscompares = 0;
  int   seq = 0;
  bit   seen_bp1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int r = 0; r < NR; r++)
      for (int b = 0; b < NB; b++) n += mq[r][b].size();
    return n;
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < NR; r++) begin
      ptr[r] = 0;
      for (int b = 0; b < NB; b++) mq[r][b].delete();
    end
  endfunction

  function automatic void predict();
    for (int r = 0; r < NR; r++) begin
      exp_v[r] = 1'b0;
      exp_b[r] = 0;
      for (int k = 0; k < NB; k++) begin
        int b;
        b = (ptr[r] + k) % NB;
        if (!exp_v[r] && mq[r][b].size() > 0) begin
          exp_v[r] = 1'b1;
          exp_b[r] = b;
          exp_d[r] = mq[r][b][0];
        end
      end
    end
    for (int b = 0; b < NB; b++) begin
      exp_rdy[b] = 1'b1;
      for (int r = 0; r < NR; r++)
        if (mq[r][b].size() >= DEPTH) exp_rdy[b] = 1'b0;
    end
  endfunction

  // One clock: check outputs mid-cycle, then apply the edge to the model.
  task automatic tick();
    @(negedge clk);
    predict();
    for (int r = 0; r < NR; r++) begin
      chk($sformatf("valid_r%0d", r), 32'(cvld[r]), 32'(exp_v[r]));
      if (exp_v[r]) chk($sformatf("data_r%0d", r), 32'(crsp[r]), 32'(exp_d[r]));
    end
    for (int b = 0; b < NB; b++) chk($sformatf("ready_b%0d", b), 32'(brdy[b]), 32'(exp_rdy[b]));
    if (!brdy[1]) seen_bp1 = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 0; r < NR; r++) begin
      if (exp_v[r]) begin
        void'(mq[r][exp_b[r]].pop_front());
        ptr[r] = (exp_b[r] + 1) % NB;
      end
    end
    for (int b = 0; b < NB; b++) begin
      if (bvld[b] && exp_rdy[b]) begin
        if (int'(brsp[b].sid) < NR) mq[brsp[b].sid][b].push_back(brsp[b]);
        bvld[b] = 1'b0;
      end
    end
  endtask

  task automatic send(input int b, input int sid, input logic [15:0] data);
    bvld[b]      = 1'b1;
    brsp[b].sid  = 2'(sid);
    brsp[b].data = data;
  endtask

  function automatic logic [15:0] tagdata(input int b);
    seq++;
    return {4'(b), 12'(seq)};
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((model_count() > 0 || bvld != '0) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drain_in_budget"}, 32'(n < budget), 32'd1);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int r = 0; r < NR; r++) chk($sformatf("%s_valid_r%0d", tag, r), 32'(cvld[r]), 32'd0);
    for (int b = 0; b < NB; b++) chk($sformatf("%s_ready_b%0d", tag, b), 32'(brdy[b]), 32'd1);
  endtask

  initial begin
    int rem [NB];
    for (int b = 0; b < NB; b++) brsp[b] = '0;
    model_reset();

    // Power-on reset.
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();

    // Single response: bank 2 to requester 1.
    send(2, 1, 16'hA5C3);
    repeat (3) tick();

    // Collision: all banks to requester 0 in one cycle.
    for (int b = 0; b < NB; b++) send(b, 0, tagdata(b));
    tick();
    repeat (5) tick();

    // Backpressure: bank 1 sends three, others flood requester 0.
    rem = '{6, 3, 6, 6};
    for (int c = 0; c < 80; c++) begin
      for (int b = 0; b < NB; b++) begin
        if (!bvld[b] && rem[b] > 0) begin
          send(b, 0, tagdata(b));
          rem[b]--;
        end
      end
      tick();
    end
    chk("bp_ready1_dropped", 32'(seen_bp1), 32'd1);
    drain("bp", 40);

    // Parallel: requesters 0 and 1 served in the same cycle.
    send(0, 0, tagdata(0));
    send(3, 1, tagdata(3));
    tick();
    chk("parallel_both_valid", 32'(cvld), 32'h3);
    repeat (2) tick();

    // Out-of-range sid is accepted and produces no output.
    send(0, 3, 16'hBAD0);
    tick();
    chk("badsid_no_output", 32'(cvld), 32'h0);
    repeat (2) tick();

    // Reset with buffered traffic discards everything.
    for (int b = 0; b < NB; b++) send(b, 0, tagdata(b));
    tick();
    for (int b = 0; b < NB; b++) send(b, (b == 3) ? 1 : 0, tagdata(b));
    tick();
    chk("pre_reset_buffered", 32'(model_count() >= 5), 32'd1);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    bvld = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) tick();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < NB; b++) begin
        if (!bvld[b] && $urandom_range(0, 99) < 60)
          send(b, $urandom_range(0, NR - 1), 16'($urandom));
      end
      tick();
    end
    drain("rand", 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
